pc_sequencer: RTL

//  Drives fetch_stage's control inputs: NextPC, Stall, Flush, Halt, Exception, Rti.

---
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   Drives the fetch stage's PC control: chooses the next fetch PC and raises
//   the Stall / Flush / Halt / Exception / Rti controls. Redirect requests from
//   decode (load-use hazard), execute (taken branch/jump) and writeback
//   (halt / exception / rti commit) are arbitrated by fixed priority:
//     rst > HALTED > HaltReq_W > ExcReq_W > RtiReq_W > Redirect_X > LoadUse_D
//   The block also holds the exception return PC (Epc) and the run/halted state.
//
// Parameters:
//   RESET_PC    PC presented while rst is high
//   EXC_VECTOR  handler address for SIIC / illegal instruction
//
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   IncPC_F      PC+2 of the current fetch
//   Redirect_X   execute resolved a taken branch/jump, target on Target_X
//   LoadUse_D    decode load-use hazard, refetch the same PC
//   HaltReq_W    HALT committed in writeback
//   ExcReq_W     SIIC/illegal committed, return PC on ExcPC_W
//   RtiReq_W     RTI committed in writeback
//   NextPC       PC fetch loads at the next edge
//   Stall/Flush/Halt/Exception/Rti  fetch control (combinational)
//   Epc          saved exception return PC
//   StallCnt/FlushCnt  saturating event counters (only with PC_SEQ_PERF_EN)
//
// Build option:
//   PC_SEQ_PERF_EN  when defined, adds the StallCnt / FlushCnt outputs.
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IncPC_F,
    input  logic        Redirect_X,
    input  logic [15:0] Target_X,
    input  logic        LoadUse_D,
    input  logic        HaltReq_W,
    input  logic        ExcReq_W,
    input  logic [15:0] ExcPC_W,
    input  logic        RtiReq_W,
    output logic [15:0] NextPC,
    output logic        Stall,
    output logic        Flush,
    output logic        Halt,
    output logic        Exception,
    output logic        Rti,
    output logic [15:0] Epc
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [15:0] StallCnt,
    output logic [15:0] FlushCnt
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] epc_q;
    logic [15:0] epc_d;
    logic [15:0] hold_pc;

    // IncPC_F is already PC+2, so the PC currently being fetched is IncPC_F-2
    // (wraps modulo 2^16).
    assign hold_pc = IncPC_F - 16'd2;

    // Next-state and output decode, one priority chain.
    always_comb begin
        state_d   = state_q;
        epc_d     = epc_q;
        NextPC    = IncPC_F;
        Stall     = 1'b0;
        Flush     = 1'b0;
        Halt      = 1'b0;
        Exception = 1'b0;
        Rti       = 1'b0;

        if (rst) begin
            NextPC = RESET_PC;
            Flush  = 1'b1;
        end else if (state_q == HALTED || HaltReq_W) begin
            // Halt freezes everything, including writeback requests behind it.
            Halt    = 1'b1;
            Stall   = 1'b1;
            NextPC  = hold_pc;
            state_d = HALTED;
        end else if (ExcReq_W) begin
            // Outranks a same-cycle RTI and any younger execute redirect.
            Exception = 1'b1;
            Flush     = 1'b1;
            NextPC    = EXC_VECTOR;
            epc_d     = ExcPC_W;
        end else if (RtiReq_W) begin
            // epc_q is the pre-edge value, so a same-cycle update never leaks in.
            Rti    = 1'b1;
            Flush  = 1'b1;
            NextPC = epc_q;
        end else if (Redirect_X) begin
            // A taken branch squashes the instruction in decode, so any
            // load-use hazard it reports is moot.
            Flush  = 1'b1;
            NextPC = Target_X;
        end else if (LoadUse_D) begin
            Stall  = 1'b1;
            NextPC = hold_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            epc_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
        end
    end

    assign Epc = epc_q;

`ifdef PC_SEQ_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Halt cycles also raise Stall but are not hazard stalls, so they are
    // excluded. Flush during rst is not counted (rst clears the counter).
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            if (Stall && !Halt) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (Flush)          flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule
